// File: rtl/uart_echo_buf_if.sv
// uart_echo_buf_if: serial lines, control inputs and status outputs of the
// UART echo buffer. Optional build macro UART_PARITY_EN adds parity_err_o.
interface uart_echo_buf_if #(
    parameter int FifoDepth     = 16,
    parameter int PrescaleWidth = 16
);
    logic [PrescaleWidth-1:0]   prescale_i;
    logic                       rx_data_i;
    logic                       tx_data_o;
    logic                       tx_pause_i;
    logic                       clear_i;
    logic [$clog2(FifoDepth):0] fifo_count_o;
    logic                       overflow_o;
    logic                       frame_err_o;
    logic                       rx_busy_o;
    logic                       tx_busy_o;
`ifdef UART_PARITY_EN
    logic                       parity_err_o;
`endif

    // master is whatever sits in front of the block (board top, bench)
    modport master (
        output prescale_i, rx_data_i, tx_pause_i, clear_i,
        input  tx_data_o, fifo_count_o, overflow_o, frame_err_o, rx_busy_o, tx_busy_o
`ifdef UART_PARITY_EN
        , input parity_err_o
`endif
    );

    // slave is the echo buffer itself
    modport slave (
        input  prescale_i, rx_data_i, tx_pause_i, clear_i,
        output tx_data_o, fifo_count_o, overflow_o, frame_err_o, rx_busy_o, tx_busy_o
`ifdef UART_PARITY_EN
        , output parity_err_o
`endif
    );
endinterface

// File: rtl/uart_echo_buf.sv
// uart_echo_buf: 8x-oversampled UART RX -> FIFO -> UART TX echo path with a
// runtime baud prescaler, TX pause, sticky error flags and FIFO occupancy.
// Build macro UART_PARITY_EN adds an even-parity bit on both directions and
// the sticky parity_err_o flag.
module uart_echo_buf #(
    parameter int DataWidth     = 8,
    parameter int FifoDepth     = 16,
    parameter int PrescaleWidth = 16
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    uart_echo_buf_if.slave bus
);
    localparam int PtrWidth = $clog2(FifoDepth);
    localparam int CntWidth = PtrWidth + 1;
    localparam int BitWidth = $clog2(DataWidth);
    localparam logic [BitWidth-1:0]      LastBit   = BitWidth'(DataWidth - 1);
    localparam logic [BitWidth-1:0]      BitOne    = BitWidth'(1);
    localparam logic [CntWidth-1:0]      FullCount = CntWidth'(FifoDepth);
    localparam logic [PrescaleWidth-1:0] POne      = PrescaleWidth'(1);

    // a prescale of zero would never tick, so it runs as one
    logic [PrescaleWidth-1:0] presc_eff;
    assign presc_eff = (bus.prescale_i == '0) ? POne : bus.prescale_i;

    // ---------------- RX line synchroniser ----------------
    logic rx_meta, rx_sync, rx_prev;

    // two synchroniser flops, then one history flop for start-edge detection
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx_data_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- FIFO ----------------
    logic                 push, pop, push_ok, pop_ok, fifo_empty, fifo_full;
    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrWidth-1:0]  wr_ptr, rd_ptr;
    logic [CntWidth-1:0]  fifo_count;
    logic [DataWidth-1:0] fifo_head;
    logic [DataWidth-1:0] rx_shift;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FullCount);
    assign pop_ok     = pop && !fifo_empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign push_ok    = push && (!fifo_full || pop_ok);
    assign fifo_head  = mem[rd_ptr];

    // storage array, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    // pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PtrWidth'(1);
            fifo_count <= fifo_count + CntWidth'(push_ok) - CntWidth'(pop_ok);
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    rx_state_e                rx_state, rx_state_d;
    logic [PrescaleWidth-1:0] rx_p, rx_div;
    logic [2:0]               rx_tcnt;
    logic [BitWidth-1:0]      rx_bcnt;
    logic                     rx_tick, rx_mid, rx_end, rx_busy_q, frame_set;
`ifdef UART_PARITY_EN
    logic                     rx_par_bad, par_set;
`endif

    assign rx_tick = (rx_state != RX_IDLE) && (rx_state != RX_WAIT_HIGH) &&
                     (rx_div == rx_p - POne);
    assign rx_mid  = rx_tick && (rx_tcnt == 3'd3);
    assign rx_end  = rx_tick && (rx_tcnt == 3'd7);

    // RX state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rx_state <= RX_IDLE;
        else           rx_state <= rx_state_d;
    end

    // RX next state: start at mid-bit, then one sample per 8 ticks
    always_comb begin
        rx_state_d = rx_state;
        case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_sync) rx_state_d = RX_START;
            RX_START:     if (rx_mid) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:      if (rx_end && rx_bcnt == LastBit) rx_state_d = RX_PARITY;
            RX_PARITY:    if (rx_end) rx_state_d = RX_STOP;
`else
            RX_DATA:      if (rx_end && rx_bcnt == LastBit) rx_state_d = RX_STOP;
`endif
            RX_STOP:      if (rx_end) rx_state_d = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: push on a good stop bit, error events otherwise
    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_PARITY_EN
        par_set   = (rx_state == RX_PARITY) && rx_end && (rx_sync != ^rx_shift);
        push      = (rx_state == RX_STOP) && rx_end && rx_sync && !rx_par_bad;
`else
        push      = (rx_state == RX_STOP) && rx_end && rx_sync;
`endif
        frame_set = (rx_state == RX_STOP) && rx_end && !rx_sync;
    end

    // RX datapath: tick divider, tick/bit counters, shift register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_p       <= POne;
            rx_div     <= '0;
            rx_tcnt    <= '0;
            rx_bcnt    <= '0;
            rx_shift   <= '0;
            rx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_busy_q <= (rx_state_d != RX_IDLE);
            // prescale is tracked while idle so the value at departure sticks
            if (rx_state == RX_IDLE) begin
                rx_div <= '0;
                rx_p   <= presc_eff;
            end else begin
                rx_div <= rx_tick ? '0 : rx_div + POne;
            end
            if (rx_state_d != rx_state) rx_tcnt <= '0;
            else if (rx_tick)           rx_tcnt <= rx_tcnt + 3'd1;
            if (rx_state != RX_DATA) begin
                rx_bcnt <= '0;
            end else if (rx_end) begin
                rx_bcnt  <= rx_bcnt + BitOne;
                rx_shift <= {rx_sync, rx_shift[DataWidth-1:1]};
            end
`ifdef UART_PARITY_EN
            if (rx_state == RX_START) rx_par_bad <= 1'b0;
            else if (par_set)         rx_par_bad <= 1'b1;
`endif
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    tx_state_e                tx_state, tx_state_d;
    logic [PrescaleWidth-1:0] tx_p, tx_div;
    logic [2:0]               tx_tcnt;
    logic [BitWidth-1:0]      tx_bcnt;
    logic [DataWidth-1:0]     tx_shift, tx_shift_d;
    logic                     tx_tick, tx_end, tx_line_d, tx_data_q, tx_busy_q;
`ifdef UART_PARITY_EN
    logic                     tx_par;
`endif

    assign tx_tick = (tx_state != TX_IDLE) && (tx_div == tx_p - POne);
    assign tx_end  = tx_tick && (tx_tcnt == 3'd7);

    // TX state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) tx_state <= TX_IDLE;
        else           tx_state <= tx_state_d;
    end

    // TX next state: pause only gates the start of a new frame
    always_comb begin
        tx_state_d = tx_state;
        case (tx_state)
            TX_IDLE:   if (!fifo_empty && !bus.tx_pause_i) tx_state_d = TX_START;
            TX_START:  if (tx_end) tx_state_d = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_end && tx_bcnt == LastBit) tx_state_d = TX_PARITY;
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
`else
            TX_DATA:   if (tx_end && tx_bcnt == LastBit) tx_state_d = TX_STOP;
`endif
            TX_STOP:   if (tx_end) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: the line level is derived from the next state so the
    // registered pin changes on the same edge as the state
    always_comb begin
        pop        = (tx_state == TX_IDLE) && (tx_state_d == TX_START);
        tx_shift_d = (tx_state == TX_DATA && tx_end) ? (tx_shift >> 1) : tx_shift;
        tx_line_d  = 1'b1;
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_line_d = tx_par;
`endif
            default:   tx_line_d = 1'b1;
        endcase
    end

    // TX datapath: tick divider, counters, shift register and the line flop
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_p      <= POne;
            tx_div    <= '0;
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_shift  <= '0;
            tx_data_q <= 1'b1;
            tx_busy_q <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_data_q <= tx_line_d;
            tx_busy_q <= (tx_state_d != TX_IDLE);
            if (tx_state == TX_IDLE) begin
                tx_div <= '0;
                tx_p   <= presc_eff;
            end else begin
                tx_div <= tx_tick ? '0 : tx_div + POne;
            end
            if (tx_state_d != tx_state) tx_tcnt <= '0;
            else if (tx_tick)           tx_tcnt <= tx_tcnt + 3'd1;
            if (tx_state != TX_DATA) tx_bcnt <= '0;
            else if (tx_end)         tx_bcnt <= tx_bcnt + BitOne;
            tx_shift <= pop ? fifo_head : tx_shift_d;
`ifdef UART_PARITY_EN
            if (pop) tx_par <= ^fifo_head;
`endif
        end
    end

    // ---------------- sticky flags ----------------
    logic overflow_q, frame_err_q;
`ifdef UART_PARITY_EN
    logic parity_err_q;
`endif

    // sticky flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overflow_q   <= (push && !push_ok) || (overflow_q && !bus.clear_i);
            frame_err_q  <= frame_set || (frame_err_q && !bus.clear_i);
`ifdef UART_PARITY_EN
            parity_err_q <= par_set || (parity_err_q && !bus.clear_i);
`endif
        end
    end

    assign bus.tx_data_o    = tx_data_q;
    assign bus.fifo_count_o = fifo_count;
    assign bus.overflow_o   = overflow_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.rx_busy_o    = rx_busy_q;
    assign bus.tx_busy_o    = tx_busy_q;
`ifdef UART_PARITY_EN
    assign bus.parity_err_o = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_echo_buf.sv
// tb_uart_echo_buf: directed bench for uart_echo_buf at prescale 2
// (16 clocks per bit). Echoed characters are predicted into a queue when
// sent and checked by a line decoder on tx_data_o.
module tb_uart_echo_buf;
    localparam int DW       = 8;
    localparam int FD       = 16;
    localparam int PW       = 16;
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    uart_echo_buf_if #(.FifoDepth(FD), .PrescaleWidth(PW)) bus ();

    uart_echo_buf #(.DataWidth(DW), .FifoDepth(FD), .PrescaleWidth(PW)) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    int             checks = 0;
    int             errors = 0;
    int             tx_frames = 0;
    logic [DW-1:0]  sb[$];
    logic           mon_en = 1'b1;
`ifdef UART_PARITY_EN
    logic           force_bad_par = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.rx_data_i = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [DW-1:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ force_bad_par);
`endif
        drive_bit(stop_bit);
        bus.rx_data_i = 1'b1;
    endtask

    // waits until every predicted character was seen and TX is idle
    task automatic wait_drain(input string tag, input int max_cycles, output int used);
        used = 0;
        while (used < max_cycles &&
               !(sb.size() == 0 && bus.tx_busy_o == 1'b0 && bus.fifo_count_o == '0)) begin
            @(negedge clk);
            used++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
    endtask

    // TX line decoder, sampling each bit at its middle
    initial begin : tx_mon
        logic [DW-1:0] b;
        logic          s_start, s_stop;
`ifdef UART_PARITY_EN
        logic          s_par;
`endif
        forever begin
            @(negedge clk);
            if (reset_ni && bus.tx_data_o === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                s_start = bus.tx_data_o;
                for (int i = 0; i < DW; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = bus.tx_data_o;
                end
`ifdef UART_PARITY_EN
                repeat (BIT_CLKS) @(negedge clk);
                s_par = bus.tx_data_o;
`endif
                repeat (BIT_CLKS) @(negedge clk);
                s_stop = bus.tx_data_o;
                tx_frames++;
                if (mon_en) begin
                    check("tx_start_bit", s_start, 0);
                    check("tx_stop_bit", s_stop, 1);
`ifdef UART_PARITY_EN
                    check("tx_parity_bit", s_par, ^b);
`endif
                    check("tx_frame_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) check("tx_data", b, sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   used;
        int   frames0;
        logic seen;
        bus.prescale_i = PW'(2);
        bus.rx_data_i  = 1'b1;
        bus.tx_pause_i = 1'b0;
        bus.clear_i    = 1'b0;

        // reset state
        repeat (3) @(posedge clk); #1;
        check("rst_tx_data", bus.tx_data_o, 1);
        check("rst_fifo_count", bus.fifo_count_o, 0);
        check("rst_overflow", bus.overflow_o, 0);
        check("rst_frame_err", bus.frame_err_o, 0);
        check("rst_busy", {bus.rx_busy_o, bus.tx_busy_o}, 0);
        reset_ni = 1'b1;
        repeat (4) @(posedge clk); #1;

        // single character, end-to-end latency
        sb.push_back(8'hA5);
        fork
            send_char(8'hA5, 1'b1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.fifo_count_o != '0) seen = 1'b1;
                end
                check("t1_push_seen", seen, 1);
                if (seen) begin
                    check("t1_count_after_push", bus.fifo_count_o, 1);
                    check("t1_tx_high_push_plus1", bus.tx_data_o, 1);
                    @(negedge clk);
                    check("t1_tx_low_push_plus2", bus.tx_data_o, 0);
                    check("t1_count_after_pop", bus.fifo_count_o, 0);
                    check("t1_tx_busy", bus.tx_busy_o, 1);
                end
            end
        join
        wait_drain("t1_drain", 400, used);

        // paused TX, fill past full
        bus.tx_pause_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send_char(DW'(k), 1'b1);
            repeat (4) @(posedge clk); #1;
            if (k < 16) sb.push_back(DW'(k));
            if (k == 15) begin
                check("t2_count_full", bus.fifo_count_o, 16);
                check("t2_no_overflow_at_full", bus.overflow_o, 0);
            end
        end
        check("t2_count_still_full", bus.fifo_count_o, 16);
        check("t2_overflow", bus.overflow_o, 1);
        check("t2_tx_idle_paused", bus.tx_busy_o, 0);
        bus.tx_pause_i = 1'b0;
        wait_drain("t2_drain", 3000, used);
        check("t2_back_to_back", used <= 16 * (10 * BIT_CLKS + 1) + 8, 1);
        repeat (300) @(posedge clk); #1;
        check("t2_overflow_sticky", bus.overflow_o, 1);
        pulse_clear();
        check("t2_overflow_cleared", bus.overflow_o, 0);

        // framing error then recovery
        frames0 = tx_frames;
        send_char(8'h3C, 1'b0);
        repeat (20) @(posedge clk); #1;
        check("t3_frame_err", bus.frame_err_o, 1);
        check("t3_count", bus.fifo_count_o, 0);
        check("t3_rx_idle", bus.rx_busy_o, 0);
        check("t3_no_tx", tx_frames, frames0);
        sb.push_back(8'h55);
        send_char(8'h55, 1'b1);
        wait_drain("t3_drain", 400, used);
        pulse_clear();
        check("t3_frame_err_cleared", bus.frame_err_o, 0);

        // false start: 2-tick low glitch
        @(posedge clk); #1;
        bus.rx_data_i = 1'b0;
        repeat (4) @(posedge clk); #1;
        bus.rx_data_i = 1'b1;
        @(negedge clk);
        check("t4_rx_busy_on_glitch", bus.rx_busy_o, 1);
        repeat (30) @(posedge clk); #1;
        check("t4_rx_idle", bus.rx_busy_o, 0);
        check("t4_count", bus.fifo_count_o, 0);
        check("t4_flags", {bus.overflow_o, bus.frame_err_o}, 0);

        // reset in the middle of RX and TX data bits
        mon_en = 1'b0;
        send_char(8'h30, 1'b1);
        fork
            send_char(8'hC3, 1'b1);
            begin
                repeat (40) @(negedge clk);
                check("t5_both_busy", {bus.rx_busy_o, bus.tx_busy_o}, 2'b11);
                check("t5_tx_low_before_rst", bus.tx_data_o, 0);
                #1;
                reset_ni = 1'b0;
                #1;
                check("t5_async_tx_high", bus.tx_data_o, 1);
                check("t5_async_count", bus.fifo_count_o, 0);
                check("t5_async_busy", {bus.rx_busy_o, bus.tx_busy_o}, 0);
            end
        join
        repeat (3) @(posedge clk); #1;
        reset_ni = 1'b1;
        repeat (250) @(posedge clk); #1;
        check("t5_tx_idle_after_rst", bus.tx_data_o, 1);
        sb.delete();
        mon_en = 1'b1;
        sb.push_back(8'h81);
        send_char(8'h81, 1'b1);
        wait_drain("t5_drain", 400, used);

`ifdef UART_PARITY_EN
        // parity good then bad
        sb.push_back(8'h07);
        send_char(8'h07, 1'b1);
        wait_drain("t6_drain", 400, used);
        check("t6_no_parity_err", bus.parity_err_o, 0);
        force_bad_par = 1'b1;
        frames0 = tx_frames;
        send_char(8'h07, 1'b1);
        repeat (60) @(posedge clk); #1;
        check("t6_parity_err", bus.parity_err_o, 1);
        check("t6_count", bus.fifo_count_o, 0);
        check("t6_no_tx", tx_frames, frames0);
        pulse_clear();
        check("t6_parity_err_cleared", bus.parity_err_o, 0);
        force_bad_par = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_echo_buf.md
Name: uart_echo_buf

Overview:
- Parametrised successor to the fixed-rate UART echo core.
- 8x-oversampled UART receiver feeds a DataWidth-wide FIFO of FifoDepth entries, which drains into a UART transmitter.
- Baud divisor is set at runtime, not fixed at elaboration.
- Adds TX pause, sticky overflow/framing flags and FIFO occupancy; sits directly behind the board PLL in the top level.

Parameters:
- DataWidth, 8, bits per UART character (5..9), sent LSB first.
- FifoDepth, 16, FIFO entries; power of two, >= 2.
- PrescaleWidth, 16, width of prescale_i.

Ports:
- clk_i  input  1  single system clock.
- reset_ni  input  1  asynchronous, active-low reset.
- prescale_i  input  PrescaleWidth  clocks per oversample tick, i.e. f_clk/(baud*8).
- rx_data_i  input  1  serial in; idles high; asynchronous to clk_i.
- tx_data_o  output  1  serial out; idles high.
- tx_pause_i  input  1  while 1, TX does not start a new frame; a frame already in progress completes.
- clear_i  input  1  one-cycle pulse; clears the sticky flags.
- fifo_count_o  output  $clog2(FifoDepth)+1  FIFO occupancy.
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err_o  output  1  sticky: a stop bit was sampled low.
- rx_busy_o, tx_busy_o  output  1  high while the respective FSM is not IDLE.

Behaviour:
- Reset, asynchronous:
  - tx_data_o=1; all flags, counts, FIFO pointers and busy outputs =0.
  - Both FSMs go to IDLE.
  - Asserting reset mid-frame aborts the frame immediately.
- Tick generators:
  - Separate tick generators for RX and TX.
  - Each counts 0..P-1 and emits a one-cycle tick at P-1.
  - P is prescale_i latched when the FSM leaves IDLE; a value of 0 is treated as 1.
  - One bit period = 8 ticks.
- RX input: rx_data_i passes through a 2-flop synchroniser; only the synchronised value is used.
- RX FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: a synchronised falling edge moves to START and resets the tick counter.
  - START: on the 4th tick (mid-bit), line low goes to DATA; line high is a false start and returns to IDLE.
  - DATA: samples every 8th tick, DataWidth times, LSB first.
  - STOP: samples on the 8th tick.
    - High: push the character to the FIFO and return to IDLE.
    - Low: set frame_err_o, drop the character, go to WAIT_HIGH.
  - WAIT_HIGH: returns to IDLE once the synchronised line is high.
- FIFO:
  - Push while full drops the character and sets overflow_o; stored contents are unchanged.
  - Push and pop in the same cycle:
    - when full: both occur, count unchanged;
    - when empty: the push occurs, the pop is ignored.
  - fifo_count_o updates the cycle after a push or pop.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: with FIFO non-empty and tx_pause_i=0, pop in cycle N; tx_data_o=0 from cycle N+1.
  - START lasts 8 ticks; DATA sends DataWidth bits LSB first, 8 ticks each; STOP drives 1 for 8 ticks.
  - After STOP, back to IDLE; the next frame may start the following cycle, giving back-to-back frames.
- End-to-end latency: with TX idle and unpaused, a character pushed in cycle M has its start bit on the line from cycle M+2.
- Flags:
  - Sticky until clear_i.
  - clear_i coinciding with a new error event leaves the flag set (set wins).
- Output timing: all outputs are registered; tx_data_o is glitch-free.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the data bits) between DATA and STOP, lasting 8 ticks.
  - RX samples this bit in a PARITY state.
  - On mismatch, RX drops the character and sets a sticky parity_err_o output (1 bit, cleared by clear_i).
- Undefined: no PARITY state, no parity bit on the line, no parity_err_o port.

Test Plan:
- prescale_i=2 (16 clk/bit); send 0xA5 with a valid stop -> push, then tx_data_o low exactly 2 cycles after the push; 0xA5 observed LSB first at 16 clk/bit; fifo_count_o goes 1 then 0.
- tx_pause_i=1; send 17 characters 0x00..0x10 -> fifo_count_o=16, overflow_o=1; release pause -> 0x00..0x0F emitted back-to-back; 0x10 never appears; clear_i -> overflow_o=0.
- Send 0x3C with stop bit forced low -> frame_err_o=1, fifo_count_o stays 0, no TX activity; line returns high, then a good 0x55 -> echoed 0x55.
- Low pulse of 2 ticks (4 clk) on idle rx_data_i -> false start rejected; rx_busy_o returns 0; nothing pushed; flags stay 0.
- Assert reset_ni low mid-DATA on both RX and TX -> tx_data_o=1 and fifo_count_o=0 asynchronously; after release, 0x81 echoes correctly.
- UART_PARITY_EN defined: 0x07 with parity bit 1 -> echoed with parity 1; same character with parity 0 -> parity_err_o=1, nothing pushed.
